lru_victim_ctrl: RTL
====================

# lru_victim_ctrl

Sequences cache miss handling around the per-set LRU tree: it selects a victim way from the LRU read port and writes back the victim if it is dirty. It then requests the refill and finally marks the refilled way as most-recently-used. It also owns the LRU update port, sharing it between the hit path and its own miss state machine. It sits between the cache tag/hit logic, the LRU instance and the memory-side writeback/refill interfaces.

## Interface
- ASSOCIATIVITY, 4, ways per set (power of two, ≥2)
- ENTRIES, 256, sets tracked by the LRU
- INDEX_BITS, 8, set index width
- WAY_BITS, 2, log2(ASSOCIATIVITY)
- HITQ_DEPTH, 4, hit-update queue depth (power of two)

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- miss_valid  in  1  miss request
- miss_ready  out  1  controller idle, miss accepted
- miss_index  in  INDEX_BITS  set of the miss
- hit_valid  in  1  hit, LRU must be updated
- hit_index  in  INDEX_BITS  set of the hit
- hit_way  in  WAY_BITS  way hit
- hit_dropped  out  1  pulse: hit update discarded
- lru_line_selector  out  INDEX_BITS  to LRU read/update index
- lru_way  in  WAY_BITS  LRU way of lru_line_selector (combinational)
- lru_update  out  1  LRU write enable
- lru_referenced_set  out  WAY_BITS  way marked MRU
- victim_index  out  INDEX_BITS  latched miss set
- victim_way  out  WAY_BITS  latched victim way
- victim_dirty  in  1  dirty bit of victim_index/victim_way (combinational)
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback accepted
- refill_valid  out  1  refill request
- refill_ready  in  1  refill accepted
- refill_done  in  1  pulse: refill data written
- done_valid  out  1  pulse: miss complete, victim_way is the filled way

## Operation
- States: IDLE, SELECT, CHECK, WB, REFILL_REQ, REFILL_WAIT, COMMIT.
- IDLE: miss_ready=1.
  - miss_valid & miss_ready latches miss_index into victim_index and moves to SELECT.
- SELECT: lru_line_selector=victim_index; victim_way<=lru_way; moves to CHECK.
- CHECK: samples victim_dirty.
  - Dirty: moves to WB.
  - Clean: moves to REFILL_REQ.
- WB: wb_valid=1 until wb_ready, then moves to REFILL_REQ.
- REFILL_REQ: refill_valid=1 until refill_ready, then moves to REFILL_WAIT.
- REFILL_WAIT: waits for refill_done, then moves to COMMIT.
  - refill_done in any other state is ignored.
- COMMIT:
  - lru_update=1, lru_line_selector=victim_index, lru_referenced_set=victim_way, done_valid=1.
  - Moves to IDLE.
- LRU port ownership: the FSM owns the port in SELECT and COMMIT; the hit path owns it in all other states.
- Hit path, port free:
  - Queue non-empty: the queue head drives the update, and a new hit is enqueued to preserve order.
  - Queue empty: the hit drives the port combinationally (line_selector=hit_index, lru_update=1, referenced_set=hit_way).
- Hit path, port busy: the hit is enqueued (see Configuration).
- Hit and miss acceptance in the same IDLE cycle: both proceed; the hit uses the port.
- Queue full with hit needing enqueue: hit discarded, hit_dropped=1 for that cycle.
- Enqueue and dequeue in the same cycle are allowed when full.
- A hit to victim_index between SELECT and COMMIT is legal; the COMMIT update is final.

## Timing
- Reset values: state IDLE, queue empty.
  - miss_ready=1.
  - wb_valid, refill_valid, lru_update, done_valid, hit_dropped = 0.
  - victim_index, victim_way = 0.
- Reset asserted mid-miss aborts it: IDLE next cycle, no done_valid, pending requests dropped.
- Clean-miss latency: accept at cycle 0, SELECT at 1, CHECK at 2, REFILL_REQ at 3.
  - COMMIT/done_valid occurs 1 cycle after refill_done.
  - miss_ready is high again the cycle after COMMIT.
- A dirty miss adds the WB cycles (≥1).
- wb_valid and refill_valid are held stable until their ready is seen.
- victim_index and victim_way are stable from CHECK to COMMIT.
- Queue drains one entry per port-free cycle.

## Configuration
- LRU_HIT_QUEUE_EN defined: a HITQ_DEPTH-entry FIFO buffers hits as above.
- Undefined: no FIFO. A hit arriving in SELECT or COMMIT is discarded with a hit_dropped pulse; other hits pass through unchanged.

## Structure
- Package lru_ctrl_pkg: state enum lru_ctrl_state_t, hit-entry struct {index, way}.
- Sub-module lru_hit_fifo: synchronous FIFO with full/empty flags and wrap-around pointers, instantiated only under LRU_HIT_QUEUE_EN.

## Test plan
- Clean miss, index 0x12, lru_way=2, victim_dirty=0, refill_ready=1, refill_done at cycle 6 -> victim_way=2, no wb_valid; done_valid and lru_update with referenced_set=2 at cycle 7.
- Dirty miss, wb_ready delayed 3 cycles -> wb_valid held 4 cycles; refill_valid only afterward; done_valid once.
- Hits at index 0x05 in SELECT and COMMIT with the macro on -> both applied in order in the next free cycles; no hit_dropped.
- Five consecutive hits during SELECT/COMMIT-blocked periods, depth 4 -> fifth raises hit_dropped; macro off -> each blocked hit raises hit_dropped.
- rst in REFILL_WAIT -> next cycle IDLE, miss_ready=1, refill_done ignored, no done_valid.
- Hit and miss in the same IDLE cycle -> hit drives lru_update that cycle; miss enters SELECT.

Source files
------------

// File: rtl/lru_ctrl_pkg.sv
// Shared types for the LRU victim controller: FSM state encoding and the
// hit-update entry buffered while the LRU port is owned by the miss FSM.
package lru_ctrl_pkg;

  localparam int LRU_INDEX_BITS = 8;
  localparam int LRU_WAY_BITS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SELECT      = 3'd1,
    ST_CHECK       = 3'd2,
    ST_WB          = 3'd3,
    ST_REFILL_REQ  = 3'd4,
    ST_REFILL_WAIT = 3'd5,
    ST_COMMIT      = 3'd6
  } lru_ctrl_state_t;

  typedef struct packed {
    logic [LRU_INDEX_BITS-1:0] index;
    logic [LRU_WAY_BITS-1:0]   way;
  } lru_hit_entry_t;

endpackage

// File: rtl/lru_hit_fifo.sv
// Synchronous hit-update FIFO with wrap-bit pointers. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module lru_hit_fifo
  import lru_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  lru_hit_entry_t wdata,
  output lru_hit_entry_t rdata,
  output logic           full,
  output logic           empty
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lru_hit_entry_t      mem_r [DEPTH];
  logic [PTR_BITS:0]   wr_ptr_r;
  logic [PTR_BITS:0]   rd_ptr_r;
  logic                do_push_s;
  logic                do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_BITS] != rd_ptr_r[PTR_BITS]) &&
                     (wr_ptr_r[PTR_BITS-1:0] == rd_ptr_r[PTR_BITS-1:0]);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[PTR_BITS-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{PTR_BITS{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{PTR_BITS{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[PTR_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/lru_victim_ctrl.sv
// Miss sequencer around the per-set LRU: victim select, writeback, refill,
// MRU commit, and arbitration of the LRU update port with the hit path.
// Optional hit-update queue enabled by defining LRU_HIT_QUEUE_EN.
module lru_victim_ctrl
  import lru_ctrl_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int ENTRIES       = 256,
  parameter int INDEX_BITS    = 8,
  parameter int WAY_BITS      = 2,
  parameter int HITQ_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [INDEX_BITS-1:0] miss_index,
  input  logic                  hit_valid,
  input  logic [INDEX_BITS-1:0] hit_index,
  input  logic [WAY_BITS-1:0]   hit_way,
  output logic                  hit_dropped,
  output logic [INDEX_BITS-1:0] lru_line_selector,
  input  logic [WAY_BITS-1:0]   lru_way,
  output logic                  lru_update,
  output logic [WAY_BITS-1:0]   lru_referenced_set,
  output logic [INDEX_BITS-1:0] victim_index,
  output logic [WAY_BITS-1:0]   victim_way,
  input  logic                  victim_dirty,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  refill_valid,
  input  logic                  refill_ready,
  input  logic                  refill_done,
  output logic                  done_valid
);

  if (ASSOCIATIVITY != (1 << WAY_BITS) || ENTRIES > (1 << INDEX_BITS) ||
      (HITQ_DEPTH & (HITQ_DEPTH - 1)) != 0 ||
      INDEX_BITS != LRU_INDEX_BITS || WAY_BITS != LRU_WAY_BITS) begin : g_bad_cfg
    $error("lru_victim_ctrl: inconsistent parameters");
  end

  lru_ctrl_state_t       state_r;
  lru_ctrl_state_t       state_next_s;
  logic [INDEX_BITS-1:0] victim_index_r;
  logic [WAY_BITS-1:0]   victim_way_r;
  logic                  fsm_owns_s;
  logic                  commit_s;

  assign victim_index = victim_index_r;
  assign victim_way   = victim_way_r;

  // Miss FSM state and victim latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      victim_index_r <= '0;
      victim_way_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_IDLE && miss_valid) victim_index_r <= miss_index;
      if (state_r == ST_SELECT)             victim_way_r   <= lru_way;
    end
  end

  // Miss FSM next-state and handshake outputs.
  always_comb begin
    state_next_s = state_r;
    miss_ready   = 1'b0;
    wb_valid     = 1'b0;
    refill_valid = 1'b0;
    done_valid   = 1'b0;
    fsm_owns_s   = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_next_s = ST_SELECT;
        else            state_next_s = ST_IDLE;
      end
      ST_SELECT: begin
        fsm_owns_s   = 1'b1;
        state_next_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (victim_dirty) state_next_s = ST_WB;
        else              state_next_s = ST_REFILL_REQ;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next_s = ST_REFILL_REQ;
        else          state_next_s = ST_WB;
      end
      ST_REFILL_REQ: begin
        refill_valid = 1'b1;
        if (refill_ready) state_next_s = ST_REFILL_WAIT;
        else              state_next_s = ST_REFILL_REQ;
      end
      ST_REFILL_WAIT: begin
        if (refill_done) state_next_s = ST_COMMIT;
        else             state_next_s = ST_REFILL_WAIT;
      end
      ST_COMMIT: begin
        fsm_owns_s   = 1'b1;
        commit_s     = 1'b1;
        done_valid   = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

`ifdef LRU_HIT_QUEUE_EN
  lru_hit_entry_t q_head_s;
  lru_hit_entry_t q_wdata_s;
  logic           q_push_s;
  logic           q_pop_s;
  logic           q_full_s;
  logic           q_empty_s;

  assign q_wdata_s = '{index: hit_index, way: hit_way};

  lru_hit_fifo #(
    .DEPTH (HITQ_DEPTH)
  ) u_hit_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_s),
    .pop   (q_pop_s),
    .wdata (q_wdata_s),
    .rdata (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s)
  );

  // LRU port arbitration: FSM first, then queued hits in order, then live hit.
  always_comb begin
    lru_line_selector  = hit_index;
    lru_referenced_set = hit_way;
    lru_update         = 1'b0;
    hit_dropped        = 1'b0;
    q_push_s           = 1'b0;
    q_pop_s            = 1'b0;
    if (fsm_owns_s) begin
      lru_line_selector  = victim_index_r;
      lru_referenced_set = victim_way_r;
      lru_update         = commit_s;
      q_push_s           = hit_valid;
      hit_dropped        = hit_valid & q_full_s;
    end else if (!q_empty_s) begin
      lru_line_selector  = q_head_s.index;
      lru_referenced_set = q_head_s.way;
      lru_update         = 1'b1;
      q_pop_s            = 1'b1;
      q_push_s           = hit_valid;
    end else begin
      lru_update         = hit_valid;
    end
  end
`else
  // LRU port arbitration: a hit colliding with FSM ownership is discarded.
  always_comb begin
    lru_line_selector  = hit_index;
    lru_referenced_set = hit_way;
    lru_update         = 1'b0;
    hit_dropped        = 1'b0;
    if (fsm_owns_s) begin
      lru_line_selector  = victim_index_r;
      lru_referenced_set = victim_way_r;
      lru_update         = commit_s;
      hit_dropped        = hit_valid;
    end else begin
      lru_update         = hit_valid;
    end
  end
`endif

endmodule
